// File: rtl/disp_pkg.sv
// Shared display constants for the digit scanner and related display blocks.
// Provides the nibble width, the blank code and the largest supported digit count.
package disp_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;
  localparam int MAX_DIGITS = 8;

endpackage

// File: rtl/digit_scan_if.sv
// Frame-load and display bus between a frame source and digit_scan.
// master: iLoad/iValue out, oData/oSel/oPending in; slave is the reverse.
interface digit_scan_if #(
  parameter int DIGITS = 8
);
  import disp_pkg::*;

  logic                        iLoad;
  logic [DIGIT_W*DIGITS-1:0]   iValue;
  logic [DIGIT_W-1:0]          oData;
  logic [DIGITS-1:0]           oSel;
  logic                        oPending;

  modport master (
    output iLoad, iValue,
    input  oData, oSel, oPending
  );

  modport slave (
    input  iLoad, iValue,
    output oData, oSel, oPending
  );

endinterface

// File: rtl/scan_tick.sv
// Free-running divider: oTick pulses one cycle every DIV clocks (DIV=1 -> always).
// Ports: iClk clock, iRst async active-high reset, oTick slot strobe.
module scan_tick #(
  parameter int DIV = 100000
) (
  input  logic iClk,
  input  logic iRst,
  output logic oTick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // With DIV=1 the counter is stuck at 0, which equals DIV-1.
  assign oTick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (oTick) cnt_d = '0;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/digit_scan.sv
// Multiplexed BCD display scanner with double-buffered frame loads.
// Ports: iClk, iRst (async, active-high), bus (slave): iLoad, iValue in;
//   oData nibble, oSel active-low digit select, oPending frame waiting.
// Optional macro DIGIT_SCAN_LZ_BLANK_EN enables leading-zero blanking.
module digit_scan
  import disp_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000
) (
  input  logic         iClk,
  input  logic         iRst,
  digit_scan_if.slave  bus
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef logic [DIGITS-1:0][DIGIT_W-1:0] frame_t;

  logic               tick;
  logic               last;
  logic               wrap;
  logic [IW-1:0]      idx_q, idx_d;
  frame_t             disp_q, disp_d;
  frame_t             shad_q, shad_d;
  frame_t             new_f;
  logic               pend_q, pend_d;
  logic [DIGIT_W-1:0] cur;
  logic [DIGIT_W-1:0] data_q, data_d;
  logic [DIGITS-1:0]  sel_q, sel_d;

  scan_tick #(.DIV(DIV)) u_tick (
    .iClk  (iClk),
    .iRst  (iRst),
    .oTick (tick)
  );

  assign last  = (idx_q == IW'(DIGITS - 1));
  assign wrap  = tick & last;
  assign new_f = frame_t'(bus.iValue);

  always_comb begin
    idx_d = idx_q;
    if (tick) idx_d = last ? '0 : idx_q + 1'b1;
  end

  // A load on the wrap cycle bypasses the shadow so it is not delayed a frame.
  always_comb begin
    disp_d = disp_q;
    shad_d = shad_q;
    pend_d = pend_q;
    if (bus.iLoad && wrap) begin
      disp_d = new_f;
      pend_d = 1'b0;
    end else if (wrap && pend_q) begin
      disp_d = shad_q;
      pend_d = 1'b0;
    end else if (bus.iLoad) begin
      shad_d = new_f;
      pend_d = 1'b1;
    end
  end

`ifdef DIGIT_SCAN_LZ_BLANK_EN
  // lz[k]: digit k and every more-significant digit are zero.
  logic [DIGITS-1:0] lz;

  always_comb begin : lz_scan
    logic z;
    z  = 1'b1;
    lz = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      z     = z & (disp_q[k] == '0);
      lz[k] = z;
    end
  end

  always_comb begin
    cur = disp_q[idx_q];
    if ((idx_q != '0) && lz[idx_q]) cur = BLANK_CODE;
  end
`else
  always_comb begin
    cur = disp_q[idx_q];
  end
`endif

  always_comb begin
    sel_d  = ~(DIGITS'(1) << idx_q);
    data_d = cur;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      idx_q  <= '0;
      disp_q <= '1;
      shad_q <= '1;
      pend_q <= 1'b0;
      data_q <= BLANK_CODE;
      sel_q  <= '1;
    end else begin
      idx_q  <= idx_d;
      disp_q <= disp_d;
      shad_q <= shad_d;
      pend_q <= pend_d;
      data_q <= data_d;
      sel_q  <= sel_d;
    end
  end

  assign bus.oData    = data_q;
  assign bus.oSel     = sel_q;
  assign bus.oPending = pend_q;

endmodule

// File: tb/tb_digit_scan.sv
// Self-checking bench for digit_scan (DIGITS=4, DIV=4 plus a DIV=1 instance).
// Expected outputs come from a cycle-count based reference model.
module tb_digit_scan;

  localparam int DG = 4;
  localparam int DV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  digit_scan_if #(.DIGITS(DG)) bus  ();
  digit_scan_if #(.DIGITS(DG)) bus1 ();

  digit_scan #(.DIGITS(DG), .DIV(DV)) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus.slave)
  );

  digit_scan #(.DIGITS(DG), .DIV(1)) dut1 (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus1.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: n = clocks since reset release.
  int          n;
  logic [3:0]  md [DG];
  logic [3:0]  ms [DG];
  logic        mp;
  logic [3:0]  ed;
  logic [DG-1:0] es;
  logic        ep;

  function automatic logic [3:0] shown(input int k);
    logic allz;
    allz = 1'b1;
    for (int j = k; j < DG; j++) if (md[j] != 4'h0) allz = 1'b0;
`ifdef DIGIT_SCAN_LZ_BLANK_EN
    if (k > 0 && allz) return 4'hF;
`endif
    return md[k];
  endfunction

  task automatic mreset();
    n = 0;
    for (int k = 0; k < DG; k++) begin
      md[k] = 4'hF;
      ms[k] = 4'hF;
    end
    mp = 1'b0;
    ed = 4'hF;
    es = '1;
    ep = 1'b0;
  endtask

  // Called at a negedge; drives inputs, advances one clock, returns at negedge.
  task automatic cyc(input logic ld, input logic [15:0] v);
    int   idx;
    logic tick, wrap;
    bus.iLoad  = ld;
    bus.iValue = v;
    idx  = (n / DV) % DG;
    tick = (n % DV) == DV - 1;
    wrap = tick && (idx == DG - 1);
    es = ~(4'(1) << idx);
    ed = shown(idx);
    if (ld && wrap) begin
      for (int k = 0; k < DG; k++) md[k] = v[4*k +: 4];
      mp = 1'b0;
    end else if (wrap && mp) begin
      for (int k = 0; k < DG; k++) md[k] = ms[k];
      mp = 1'b0;
    end else if (ld) begin
      for (int k = 0; k < DG; k++) ms[k] = v[4*k +: 4];
      mp = 1'b1;
    end
    n++;
    ep = mp;
    @(posedge clk);
    @(negedge clk);
    bus.iLoad  = 1'b0;
    bus.iValue = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.oData !== 4'hF) begin
      errors++; $display("FAIL reset_data got %h want f", bus.oData);
    end
    checks++;
    if (bus.oSel !== 4'b1111) begin
      errors++; $display("FAIL reset_sel got %b want 1111", bus.oSel);
    end
    checks++;
    if (bus.oPending !== 1'b0) begin
      errors++; $display("FAIL reset_pend got %b want 0", bus.oPending);
    end
    mreset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_scan();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 16'h0);
      if (i == 0) begin
        checks++;
        if (bus.oSel !== 4'b1110) begin
          errors++; $display("FAIL first_sel got %b want 1110", bus.oSel);
        end
      end
      checks++;
      if (bus.oSel !== es || bus.oData !== ed || bus.oPending !== ep) begin
        errors++;
        $display("FAIL scan n=%0d sel %b/%b data %h/%h pend %b/%b",
                 n, bus.oSel, es, bus.oData, ed, bus.oPending, ep);
      end
    end
  endtask

  task automatic run_chk(input string nm, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      cyc(1'b0, 16'h0);
      checks++;
      if (bus.oSel !== es || bus.oData !== ed || bus.oPending !== ep) begin
        errors++;
        $display("FAIL %s n=%0d sel %b/%b data %h/%h pend %b/%b",
                 nm, n, bus.oSel, es, bus.oData, ed, bus.oPending, ep);
      end
    end
  endtask

  task automatic test_load_mid();
    while (n % 16 != 6) run_chk("align", 1);
    cyc(1'b1, 16'h1234);
    checks++;
    if (bus.oPending !== 1'b1) begin
      errors++; $display("FAIL load_pend got %b want 1", bus.oPending);
    end
    run_chk("load_mid", 40);
  endtask

  task automatic test_last_wins();
    while (n % 16 != 1) run_chk("align", 1);
    cyc(1'b1, 16'h1111);
    run_chk("last_a", 3);
    cyc(1'b1, 16'h5678);
    checks++;
    if (bus.oPending !== 1'b1) begin
      errors++; $display("FAIL last_pend got %b want 1", bus.oPending);
    end
    run_chk("last_wins", 40);
  endtask

  task automatic test_wrap_load();
    while (n % 16 != 15) run_chk("align", 1);
    cyc(1'b1, 16'h9999);
    checks++;
    if (bus.oPending !== 1'b0) begin
      errors++; $display("FAIL wrap_pend got %b want 0", bus.oPending);
    end
    run_chk("wrap_load", 24);
  endtask

  task automatic test_reset_pending();
    while (n % 16 != 5) run_chk("align", 1);
    cyc(1'b1, 16'h4321);
    checks++;
    if (bus.oPending !== 1'b1) begin
      errors++; $display("FAIL rp_pend got %b want 1", bus.oPending);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.oData !== 4'hF || bus.oSel !== 4'b1111 || bus.oPending !== 1'b0) begin
      errors++;
      $display("FAIL rp_async data %h sel %b pend %b want f 1111 0",
               bus.oData, bus.oSel, bus.oPending);
    end
    mreset();
    @(negedge clk);
    rst = 1'b0;
    run_chk("rp_after", 40);
  endtask

  task automatic test_random();
    logic        ld;
    logic [15:0] v;
    for (int i = 0; i < 400; i++) begin
      ld = ($urandom_range(0, 7) == 0);
      v  = 16'($urandom);
      cyc(ld, v);
      checks++;
      if (bus.oSel !== es || bus.oData !== ed || bus.oPending !== ep) begin
        errors++;
        $display("FAIL random n=%0d sel %b/%b data %h/%h pend %b/%b",
                 n, bus.oSel, es, bus.oData, ed, bus.oPending, ep);
      end
    end
  endtask

  task automatic test_blank();
    logic [3:0] t40 [4];
    logic [3:0] t00 [4];
    int idx;
`ifdef DIGIT_SCAN_LZ_BLANK_EN
    t40 = '{4'h0, 4'h4, 4'hF, 4'hF};
    t00 = '{4'h0, 4'hF, 4'hF, 4'hF};
`else
    t40 = '{4'h0, 4'h4, 4'h0, 4'h0};
    t00 = '{4'h0, 4'h0, 4'h0, 4'h0};
`endif
    cyc(1'b1, 16'h0040);
    run_chk("blank_a", 32);
    for (int i = 0; i < 16; i++) begin
      idx = (n / DV) % DG;
      cyc(1'b0, 16'h0);
      checks++;
      if (bus.oData !== t40[idx]) begin
        errors++;
        $display("FAIL blank_0040 slot %0d got %h want %h", idx, bus.oData, t40[idx]);
      end
    end
    cyc(1'b1, 16'h0000);
    run_chk("blank_b", 32);
    for (int i = 0; i < 16; i++) begin
      idx = (n / DV) % DG;
      cyc(1'b0, 16'h0);
      checks++;
      if (bus.oData !== t00[idx]) begin
        errors++;
        $display("FAIL blank_0000 slot %0d got %h want %h", idx, bus.oData, t00[idx]);
      end
    end
  endtask

  task automatic test_div1();
    logic [3:0] want;
    rst = 1'b1;
    @(negedge clk);
    mreset();
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 16'h0);
      want = ~(4'(1) << (i % 4));
      checks++;
      if (bus1.oSel !== want) begin
        errors++; $display("FAIL div1_sel i=%0d got %b want %b", i, bus1.oSel, want);
      end
    end
  endtask

  initial begin
    bus.iLoad   = 1'b0;
    bus.iValue  = '0;
    bus1.iLoad  = 1'b0;
    bus1.iValue = '0;
    mreset();
    test_reset();
    test_scan();
    test_load_mid();
    test_last_wins();
    test_wrap_load();
    test_reset_pending();
    test_random();
    test_blank();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
